// File: rtl/dm_wait_responder.sv
// Purpose: word RAM behind the CPU data port; each load/store is answered after WAIT wait states.
// Latency: ready pulses WAIT+1 cycles after the accept edge; rdata/err are registered with ready.
// Backpressure: stall = req & ~ready holds the pipeline; a new access is accepted only from idle.
//
// Ports:
//   clk, rstn         - CPU clock, asynchronous active-low reset
//   req, we           - access request (held until ready) and store/load select
//   addr, wdata, be   - byte address, store data, byte enables (be[i] -> wdata[8i+7:8i])
//   rdata, ready, err - registered load data, one-cycle completion pulse, error flag (valid with ready)
//   stall             - combinational pipeline stall
module dm_wait_responder #(
    parameter int ADDR_W = 7,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       commit;

    // Access fields captured at the accept edge.
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    // Fields used at the commit edge. With WAIT=0 the commit happens on the
    // accept edge itself, before the capture registers hold anything, so the
    // live inputs are used while still in idle.
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_be    = cap_be;
        if (state == ST_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end
    end

    // Misaligned, or any address bit above the RAM word index set.
    assign acc_err = (|acc_addr[1:0]) | (|acc_addr[31:ADDR_W+2]);
    assign acc_idx = acc_addr[ADDR_W+1:2];

    // commit marks the edge that enters DONE: the access is performed there.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_nxt = ST_DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= commit;
            err   <= commit & acc_err;
            if (state == ST_IDLE && req) begin
                cap_we    <= we;
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_be    <= be;
            end
            // Only loads touch rdata; an erroring load clears it.
            if (commit && !acc_we) begin
                rdata <= acc_err ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // RAM contents survive reset; an aborted access never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign stall = req & ~ready;

endmodule

// File: tb/tb_dm_wait_responder.sv
// Purpose: directed bench for dm_wait_responder with WAIT=2 and WAIT=0 instances.
// Latency: a transaction-level model predicts ready/err/rdata per edge.
// Backpressure: accesses are driven with req held or withdrawn after accept.
module tb_dm_wait_responder;

    localparam int AW = 7;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  be_v    [2];
    logic [31:0] rdata_v [2];
    logic        ready_v [2];
    logic        err_v   [2];
    logic        stall_v [2];

    dm_wait_responder #(.ADDR_W(AW), .WAIT(2)) u_w2 (
        .clk(clk), .rstn(rstn), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .err(err_v[0]), .stall(stall_v[0])
    );

    dm_wait_responder #(.ADDR_W(AW), .WAIT(0)) u_w0 (
        .clk(clk), .rstn(rstn), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .err(err_v[1]), .stall(stall_v[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wt(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // ---------------- transaction-level model ----------------
    // An access accepted at edge n completes at edge n+WAIT; the next accept
    // may happen no earlier than edge n+WAIT+2.
    logic [31:0] mmem [2][128];
    int          ecnt = 0;
    int          pend   [2] = '{-1, -1};
    int          free_e [2] = '{0, 0};
    logic        p_we   [2];
    logic        p_err  [2];
    logic [6:0]  p_idx  [2];
    logic [31:0] p_wd   [2];
    logic [3:0]  p_be   [2];
    logic        m_ready [2] = '{1'b0, 1'b0};
    logic        m_err   [2] = '{1'b0, 1'b0};
    logic [31:0] m_rdata [2] = '{32'd0, 32'd0};

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                pend[i]    = -1;
                free_e[i]  = 0;
                m_ready[i] = 1'b0;
                m_err[i]   = 1'b0;
                m_rdata[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ready[i] = 1'b0;
                m_err[i]   = 1'b0;
                if (req_v[i] === 1'b1 && ecnt >= free_e[i]) begin
                    p_we[i]   = we_v[i];
                    p_err[i]  = (addr_v[i] % 4 != 0) || ((addr_v[i] >> (AW + 2)) != 0);
                    p_idx[i]  = 7'((addr_v[i] >> 2) % 128);
                    p_wd[i]   = wdata_v[i];
                    p_be[i]   = be_v[i];
                    pend[i]   = ecnt + wt(i);
                    free_e[i] = ecnt + wt(i) + 2;
                end
                if (pend[i] == ecnt) begin
                    m_ready[i] = 1'b1;
                    m_err[i]   = p_err[i];
                    if (p_we[i]) begin
                        if (!p_err[i]) begin
                            for (int b = 0; b < 4; b++)
                                if (p_be[i][b]) mmem[i][p_idx[i]][8*b +: 8] = p_wd[i][8*b +: 8];
                        end
                    end else begin
                        m_rdata[i] = p_err[i] ? 32'd0 : mmem[i][p_idx[i]];
                    end
                    pend[i] = -1;
                end
            end
            ecnt++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]@%0d", i, ecnt), 32'(ready_v[i]), 32'(m_ready[i]));
            chk($sformatf("rdata[%0d]@%0d", i, ecnt), rdata_v[i], m_rdata[i]);
            chk($sformatf("stall[%0d]@%0d", i, ecnt), 32'(stall_v[i]), 32'(req_v[i] & ~m_ready[i]));
            if (m_ready[i])
                chk($sformatf("err[%0d]@%0d", i, ecnt), 32'(err_v[i]), 32'(m_err[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req_v[i]   = 1'b1;
        we_v[i]    = w;
        addr_v[i]  = a;
        wdata_v[i] = d;
        be_v[i]    = b;
    endtask

    // Waits for ready; returns cycles from accept edge, stall cycles seen, err and rdata at ready.
    task automatic wait_rdy(input int i, input logic hold, output int lat, output int st,
                            output logic e, output logic [31:0] r);
        lat = 0;
        st  = 0;
        @(negedge clk);
        st += int'(stall_v[i]);
        do begin
            @(posedge clk);
            #2;
            if (!hold) begin
                req_v[i]   = 1'b0;
                addr_v[i]  = 32'hFFFF_FFF3;
                wdata_v[i] = 32'h5A5A_5A5A;
                we_v[i]    = ~we_v[i];
            end
            @(negedge clk);
            lat++;
            st += int'(stall_v[i]);
        end while (ready_v[i] !== 1'b1 && lat < 40);
        tests++;
        if (ready_v[i] !== 1'b1) begin
            fails++;
            $display("FAIL timeout inst %0d: no ready within %0d cycles", i, lat);
        end
        e = err_v[i];
        r = rdata_v[i];
    endtask

    task automatic acc(input string nm, input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic hold,
                       input int exp_lat, input int exp_st, input logic exp_e,
                       input logic [31:0] exp_r);
        int lat, st;
        logic e;
        logic [31:0] r;
        @(posedge clk);
        #2;
        drive(i, w, a, d, b);
        wait_rdy(i, hold, lat, st, e, r);
        @(posedge clk);
        #2;
        req_v[i] = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        if (exp_st >= 0) chk({nm, " stall cycles"}, 32'(st), 32'(exp_st));
        chk({nm, " err"}, 32'(e), 32'(exp_e));
        chk({nm, " rdata"}, r, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, st, ea, eb, pulses;
        logic e;
        logic [31:0] r;

        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = 32'd0; wdata_v[i] = 32'd0; be_v[i] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", 32'(ready_v[i]), 32'd0);
            chk("reset err", 32'(err_v[i]), 32'd0);
            chk("reset rdata", rdata_v[i], 32'd0);
        end
        #1;
        rstn = 1'b1;

        // WAIT=2: seed memory, then abort a store with reset mid-wait.
        acc("st 0x000", 0, 1'b1, 32'h000, 32'hCAFE_F00D, 4'hF, 1'b1, 3, 3, 1'b0, 32'h0);
        acc("st 0x010", 0, 1'b1, 32'h010, 32'h1111_2222, 4'hF, 1'b1, 3, 3, 1'b0, 32'h0);
        acc("ld 0x010", 0, 1'b0, 32'h010, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'h1111_2222);

        @(posedge clk);
        #2;
        drive(0, 1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk);
        #2;
        req_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midwait reset ready", 32'(ready_v[0]), 32'd0);
        chk("midwait reset err", 32'(err_v[0]), 32'd0);
        chk("midwait reset rdata", rdata_v[0], 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        acc("ld 0x010 after reset", 0, 1'b0, 32'h010, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'h1111_2222);

        acc("st 0x040", 0, 1'b1, 32'h040, 32'h1234_5678, 4'hF, 1'b1, 3, 3, 1'b0, 32'h1111_2222);
        acc("ld 0x040", 0, 1'b0, 32'h040, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'h1234_5678);

        // Withdrawn request: still completes once, inputs scrambled after accept.
        acc("ld 0x040 withdrawn", 0, 1'b0, 32'h040, 32'h0, 4'hF, 1'b0, 3, 1, 1'b0, 32'h1234_5678);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(ready_v[0]);
        end
        chk("no second access", 32'(pulses), 32'd0);

        acc("st be=0101", 0, 1'b1, 32'h040, 32'hAABB_CCDD, 4'b0101, 1'b1, 3, 3, 1'b0, 32'h1234_5678);
        acc("ld merged", 0, 1'b0, 32'h040, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'h12BB_56DD);
        acc("ld misaligned", 0, 1'b0, 32'h042, 32'h0, 4'hF, 1'b1, 3, 3, 1'b1, 32'h0);
        acc("st out of range", 0, 1'b1, 32'h200, 32'h0BAD_0BAD, 4'hF, 1'b1, 3, 3, 1'b1, 32'h0);
        acc("ld 0x000", 0, 1'b0, 32'h000, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'hCAFE_F00D);
        acc("st be=0", 0, 1'b1, 32'h040, 32'h0, 4'h0, 1'b1, 3, 3, 1'b0, 32'hCAFE_F00D);
        acc("ld after be=0", 0, 1'b0, 32'h040, 32'h0, 4'hF, 1'b1, 3, 3, 1'b0, 32'h12BB_56DD);

        // WAIT=0 instance.
        acc("w0 st 0x020", 1, 1'b1, 32'h020, 32'h0102_0304, 4'hF, 1'b1, 1, 1, 1'b0, 32'h0);
        acc("w0 st 0x024", 1, 1'b1, 32'h024, 32'h0506_0708, 4'hF, 1'b1, 1, 1, 1'b0, 32'h0);

        // Back-to-back loads with req held high across both.
        @(posedge clk);
        #2;
        drive(1, 1'b0, 32'h020, 32'h0, 4'hF);
        wait_rdy(1, 1'b1, lat, st, e, r);
        ea = ecnt;
        chk("b2b first latency", 32'(lat), 32'd1);
        chk("b2b first rdata", r, 32'h0102_0304);
        @(posedge clk);
        #2;
        drive(1, 1'b0, 32'h024, 32'h0, 4'hF);
        wait_rdy(1, 1'b1, lat, st, e, r);
        eb = ecnt;
        chk("b2b second latency", 32'(lat), 32'd1);
        chk("b2b gap stall", 32'(st), 32'd1);
        chk("b2b ready spacing", 32'(eb - ea), 32'd2);
        chk("b2b second rdata", r, 32'h0506_0708);
        @(posedge clk);
        #2;
        req_v[1] = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
